// File: rtl/opfetch_pkg.sv
// Shared definitions for the operand fetch stage: instruction field layout,
// register count and the opcode that performs no register writeback.
package opfetch_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int INSTR_W_DEF = 32;
    localparam int NUM_REGS    = 16;
    localparam int REG_AW      = 4;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_MSB = 23;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOWB = 4'hF;

endpackage

// File: rtl/opfetch_scoreboard.sv
// Busy bitmap of registers with an outstanding writeback.
// A set and a clear of the same entry in one cycle leaves the entry set.
module opfetch_scoreboard
    import opfetch_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_addr,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;

    // Clear is applied first so a coincident set overrides it.
    always_comb begin
        busy_next = busy_q;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources, stalls on busy registers, registers a bundle.
// Define OPFETCH_BYPASS_EN to forward a same-cycle writeback into the operands.
module operand_fetch
    import opfetch_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic [REG_AW-1:0]  rf_raddr1,
    output logic [REG_AW-1:0]  rf_raddr2,
    input  logic [DATA_W-1:0]  rf_rdata1,
    input  logic [DATA_W-1:0]  rf_rdata2,
    input  logic               wb_valid,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_opcode,
    output logic [REG_AW-1:0]  out_rd,
    output logic [DATA_W-1:0]  out_op1,
    output logic [DATA_W-1:0]  out_op2,
    output logic [DATA_W-1:0]  out_imm
);

    logic [3:0]          opcode;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs1;
    logic [REG_AW-1:0]   rs2;
    logic [15:0]         imm;
    logic [NUM_REGS-1:0] busy;
    logic                byp1;
    logic                byp2;
    logic                hazard;
    logic                accept;
    logic [DATA_W-1:0]   op1;
    logic [DATA_W-1:0]   op2;

    assign opcode = in_instr[OPC_MSB:OPC_LSB];
    assign rd     = in_instr[RD_MSB:RD_LSB];
    assign rs1    = in_instr[RS1_MSB:RS1_LSB];
    assign rs2    = in_instr[RS2_MSB:RS2_LSB];
    assign imm    = in_instr[IMM_MSB:IMM_LSB];

    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

`ifdef OPFETCH_BYPASS_EN
    assign byp1 = wb_valid && (wb_addr == rs1);
    assign byp2 = wb_valid && (wb_addr == rs2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // rs1 == rs2 naturally looks up the same bit, so a shared source stalls once.
    assign hazard = (busy[rs1] && !byp1) || (busy[rs2] && !byp2);

    // Handshake: a beat moves on a posedge where valid && ready. in_ready is
    // combinational from out_ready and the hazard, and is held low in reset.
    // out_valid and every out_* field stay stable until out_ready is seen.
    assign in_ready = RESET && (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    assign op1 = byp1 ? wb_data : rf_rdata1;
    assign op2 = byp2 ? wb_data : rf_rdata2;

    opfetch_scoreboard u_sb (
        .CLK      (CLK),
        .RESET    (RESET),
        .set_en   (accept && (opcode != OP_NOWB)),
        .set_addr (rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .busy     (busy)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_rd     <= '0;
            out_op1    <= '0;
            out_op2    <= '0;
            out_imm    <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_opcode <= opcode;
            out_rd     <= rd;
            out_op1    <= op1;
            out_op2    <= op2;
            out_imm    <= {{(DATA_W-16){imm[15]}}, imm};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand and writeback data width.
REQ-002 SHALL have parameter INSTR_W, default 32: instruction width.
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port RESET, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: instruction offered.
REQ-006 SHALL have port in_ready, output, 1: instruction accepted when in_valid && in_ready at posedge.
REQ-007 SHALL have port in_instr, input, INSTR_W: fields opcode[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm[15:0].
REQ-008 SHALL have ports rf_raddr1 and rf_raddr2, output, 4 each: register file read addresses, driven combinationally from in_instr rs1 and rs2.
REQ-009 SHALL have ports rf_rdata1 and rf_rdata2, input, DATA_W each: combinational register file read data.
REQ-010 SHALL have ports wb_valid (1), wb_addr (4) and wb_data (DATA_W), input: writeback snoop, identical to the register file write port.
REQ-011 SHALL have port out_valid, input out_ready, and outputs out_opcode (4), out_rd (4), out_op1 (DATA_W), out_op2 (DATA_W) and out_imm (DATA_W): registered operand bundle to execute.

Function
REQ-012 SHALL hold one output pipeline register; transfer occurs when out_valid && out_ready.
REQ-013 SHALL drive in_ready = (!out_valid || out_ready) && !hazard, combinationally.
REQ-014 SHALL assert hazard when busy[rs1] or busy[rs2] is set, subject to REQ-020.
REQ-015 SHALL, on accept, register opcode, rd, rs1/rs2 operands and imm sign-extended 16->DATA_W; out_valid SHALL be 1 the following cycle, giving latency 1.
REQ-016 SHALL, on accept with opcode != OP_NOWB (4'hF), set busy[rd].
REQ-017 SHALL, when wb_valid, clear busy[wb_addr]; a clear of a non-busy entry SHALL have no effect.
REQ-018 SHALL, on a simultaneous set and clear of the same entry, let the set win.
REQ-019 SHALL hold out_valid and all out_* stable while out_valid && !out_ready.
REQ-020 SHALL, with the bypass feature enabled, on wb_valid && wb_addr == rs, treat that source as not busy and capture wb_data for it instead of rf_rdata.
REQ-021 SHALL, when rs1 == rs2 and the register is busy, stall for the same duration as a single busy source.

Reset
REQ-022 SHALL, when RESET == 0 at posedge, clear out_valid, all 16 busy bits, and out_opcode/out_rd/out_op1/out_op2/out_imm to 0.
REQ-023 SHALL, on reset mid-operation, discard any in-flight bundle with no output transfer; in_ready SHALL be 0 during the reset cycle.

Configuration
REQ-024 SHALL compile the same-cycle writeback bypass of REQ-020 in only when OPFETCH_BYPASS_EN is defined.
REQ-025 SHALL, without OPFETCH_BYPASS_EN, keep hazard asserted until the cycle after the clearing wb_valid; operands then come from rf_rdata.

Structure
REQ-026 SHALL place instruction field positions, OP_NOWB, DATA_W/INSTR_W defaults and the register count (16) in shared package opfetch_pkg.
REQ-027 SHALL implement the busy bitmap and set/clear priority in sub-module opfetch_scoreboard, with ports set_en, set_addr, clr_en, clr_addr and busy[15:0].

Verification
REQ-028 SHALL cover: reset released, instr 0x1321_FFFE accepted with r2=5, r1=7 -> next cycle out_valid=1, out_rd=3, out_op1=5, out_op2=7, out_imm=0xFFFF_FFFE, and busy[3]=1.
REQ-029 SHALL cover: back-to-back instr reading r3 while busy[3]=1 -> in_ready=0; wb_valid with wb_addr=3 and wb_data=0x2A -> accepted with op1=0x2A in the same cycle with the bypass enabled, one cycle later without it.
REQ-030 SHALL cover: out_ready=0 for 3 cycles with a new in_valid -> in_ready=0 and out_* held constant; out_ready=1 -> transfer, and the next instr is accepted in the same cycle.
REQ-031 SHALL cover: accept of rd=4 with a simultaneous wb_valid to wb_addr=4 -> busy[4]=1 afterwards.
REQ-032 SHALL cover: opcode 0xF accept -> no busy bit set; RESET=0 while out_valid=1 -> next cycle out_valid=0 and busy=0x0000.
